key_event_ctrl: RTL and testbench
=================================

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 Parameter KEY_W, 4, number of independent key channels (>=1).
REQ-002 Parameter T_DEB, 1000000, debounce window in clk cycles (>=2; 20 ms at 50 MHz).
REQ-003 Parameter T_LONG, 50000000, hold time after press pulse before long-press pulse (>=2).
REQ-004 Parameter T_REP, 10000000, auto-repeat period after long-press (>=2).
REQ-005 Parameter REPEAT_EN, 1, 1 enables auto-repeat pulses, 0 suppresses them.
REQ-006 Parameter ACTIVE_LOW, 1, 1 means raw key reads 0 when pressed.
REQ-007 clk  input  1  system clock, 50 MHz.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 key  input  KEY_W  raw asynchronous key pins.
REQ-010 key_level  output  KEY_W  debounced pressed level per key.
REQ-011 key_press  output  KEY_W  one-cycle pulse per key on debounced press.
REQ-012 key_release  output  KEY_W  one-cycle pulse per key on debounced release.
REQ-013 key_long  output  KEY_W  one-cycle pulse per key on long-press.
REQ-014 key_repeat  output  KEY_W  one-cycle pulse per key per repeat period.

Function
REQ-015 Each key SHALL pass through a two-flop synchroniser, inverted when ACTIVE_LOW=1, giving internal pressed bit k_s (1 = pressed).
REQ-016 Each channel SHALL own an independent FSM and counter of width CNT_W = clog2(max(T_DEB,T_LONG,T_REP)); channels never share state.
REQ-017 States: IDLE, DEB_P, HELD, LONG, DEB_R; counter cleared on every state change.
REQ-018 IDLE: k_s=1 -> DEB_P.
REQ-019 DEB_P: k_s=0 -> IDLE, no pulse; else count; cnt==T_DEB-1 -> HELD with key_press pulse.
REQ-020 HELD: k_s=0 -> DEB_R; else count; cnt==T_LONG-1 -> LONG with key_long pulse.
REQ-021 LONG: k_s=0 -> DEB_R; else if REPEAT_EN=1 count, and cnt==T_REP-1 -> key_repeat pulse, counter wraps to 0, stay LONG; if REPEAT_EN=0 counter holds 0.
REQ-022 DEB_R: k_s=1 -> HELD (long/repeat timing restarts, no pulse); else count; cnt==T_DEB-1 -> IDLE with key_release pulse.
REQ-023 key_level SHALL be 1 exactly in HELD, LONG, DEB_R; registered, updates same edge as state.
REQ-024 All pulse outputs SHALL be registered, high for exactly one clk cycle, mutually exclusive per channel in any cycle.
REQ-025 Latency: a clean press stable from cycle 0 SHALL raise key_press in cycle T_DEB+3; release latency identical for key_release.
REQ-026 Simultaneous events on different channels SHALL produce pulses in the same cycle with no arbitration or loss.
REQ-027 Glitches shorter than T_DEB cycles SHALL produce no pulse and no key_level change.
REQ-028 Every press SHALL yield exactly one key_release after it, so press/release counts match once all keys are idle.

Reset
REQ-029 rst high SHALL asynchronously force all FSMs to IDLE, counters and synchronisers to 0 (unpressed), all outputs to 0.
REQ-030 Reset asserted mid-press SHALL emit no release pulse; after deassertion a still-held key SHALL be re-debounced and produce key_press in cycle T_DEB+3 after rst falls.

Structure
REQ-031 Package key_event_pkg SHALL hold the state enumeration and the CNT_W width-calculation function.
REQ-032 Sub-module key_event_ch SHALL implement one synchroniser+FSM+counter channel; key_event_ctrl SHALL instantiate KEY_W copies by generate loop.

Verification (KEY_W=4, T_DEB=4, T_LONG=16, T_REP=8, ACTIVE_LOW=1)
REQ-033 key[0] driven low at cycle 0 and held 10 cycles, then high -> key_press[0] in cycle 7 only, key_level[0]=1 cycles 7..16, key_release[0] in cycle 17.
REQ-034 key[1] low for 3 cycles then high -> no pulse, key_level[1] stays 0.
REQ-035 key[2] held low 60 cycles, REPEAT_EN=1 -> key_press cycle 7, key_long cycle 23, key_repeat cycles 31, 39, 47, 55; with REPEAT_EN=0 -> no key_repeat.
REQ-036 key[3:0] all driven low at cycle 0 -> key_press=4'hF in cycle 7, single cycle.
REQ-037 key[0] held, one 2-cycle high bounce during release debounce -> state returns HELD, only one key_release after final stable release.
REQ-038 rst asserted at cycle 20 while key[0] held, deasserted at cycle 25 -> all outputs 0 during reset, no key_release, key_press[0] in cycle 32.

Source files
------------

// File: rtl/key_event_pkg.sv
// Shared types and sizing helpers for the key event controller.
package key_event_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DEB_P = 3'd1,
    HELD  = 3'd2,
    LONG  = 3'd3,
    DEB_R = 3'd4
  } ch_state_e;

  // Counter width large enough to reach the longest of the three timing windows.
  function automatic int unsigned cnt_width(input int unsigned t_deb,
                                            input int unsigned t_long,
                                            input int unsigned t_rep);
    int unsigned m;
    m = t_deb;
    if (t_long > m) m = t_long;
    if (t_rep > m) m = t_rep;
    if (m <= 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/key_event_ch.sv
// One key channel: two-flop synchroniser, debounce/long/repeat FSM and counter.
module key_event_ch
  import key_event_pkg::*;
#(
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned T_DEB      = 1000000,
  parameter int unsigned T_LONG     = 50000000,
  parameter int unsigned T_REP      = 10000000,
  parameter int unsigned REPEAT_EN  = 1,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic level,
  output logic press_p,
  output logic release_p,
  output logic long_p,
  output logic repeat_p
);

  localparam logic             INV      = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(T_DEB - 1);
  localparam logic [CNT_W-1:0] LNG_LAST = CNT_W'(T_LONG - 1);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(T_REP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync;
  logic             k_s;
  ch_state_e        state;
  logic [CNT_W-1:0] cnt;

  // Polarity is normalised before the first flop so reset means "unpressed".
  assign k_s = sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync      <= '0;
      state     <= IDLE;
      cnt       <= '0;
      level     <= 1'b0;
      press_p   <= 1'b0;
      release_p <= 1'b0;
      long_p    <= 1'b0;
      repeat_p  <= 1'b0;
    end else begin
      sync      <= {sync[0], key ^ INV};
      press_p   <= 1'b0;
      release_p <= 1'b0;
      long_p    <= 1'b0;
      repeat_p  <= 1'b0;
      case (state)
        IDLE: begin
          if (k_s) begin
            state <= DEB_P;
            cnt   <= '0;
          end
        end
        DEB_P: begin
          if (!k_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state   <= HELD;
            cnt     <= '0;
            level   <= 1'b1;
            press_p <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!k_s) begin
            state <= DEB_R;
            cnt   <= '0;
          end else if (cnt == LNG_LAST) begin
            state  <= LONG;
            cnt    <= '0;
            long_p <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        LONG: begin
          if (!k_s) begin
            state <= DEB_R;
            cnt   <= '0;
          end else if (REPEAT_EN != 0) begin
            if (cnt == REP_LAST) begin
              cnt      <= '0;
              repeat_p <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end else begin
            cnt <= '0;
          end
        end
        DEB_R: begin
          // A bounce back to pressed returns to HELD and restarts long timing.
          if (k_s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            level     <= 1'b0;
            release_p <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Multi-key debouncer producing level, press, release, long-press and repeat events.
module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter int unsigned KEY_W      = 4,
  parameter int unsigned T_DEB      = 1000000,
  parameter int unsigned T_LONG     = 50000000,
  parameter int unsigned T_REP      = 10000000,
  parameter int unsigned REPEAT_EN  = 1,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key,
  output logic [KEY_W-1:0] key_level,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_long,
  output logic [KEY_W-1:0] key_repeat
);

  localparam int unsigned CNT_W = cnt_width(T_DEB, T_LONG, T_REP);

  for (genvar i = 0; i < KEY_W; i++) begin : g_ch
    key_event_ch #(
      .CNT_W     (CNT_W),
      .T_DEB     (T_DEB),
      .T_LONG    (T_LONG),
      .T_REP     (T_REP),
      .REPEAT_EN (REPEAT_EN),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .key      (key[i]),
      .level    (key_level[i]),
      .press_p  (key_press[i]),
      .release_p(key_release[i]),
      .long_p   (key_long[i]),
      .repeat_p (key_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with repeat enabled and disabled instances.
module tb_key_event_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] key;
  logic [3:0] lvl_a, prs_a, rel_a, lng_a, rep_a;
  logic [3:0] lvl_b, prs_b, rel_b, lng_b, rep_b;

  int n_cmp;
  int n_err;

  key_event_ctrl #(
    .KEY_W(4), .T_DEB(4), .T_LONG(16), .T_REP(8), .REPEAT_EN(1), .ACTIVE_LOW(1)
  ) dut_a (
    .clk(clk), .rst(rst), .key(key),
    .key_level(lvl_a), .key_press(prs_a), .key_release(rel_a),
    .key_long(lng_a), .key_repeat(rep_a)
  );

  key_event_ctrl #(
    .KEY_W(4), .T_DEB(4), .T_LONG(16), .T_REP(8), .REPEAT_EN(0), .ACTIVE_LOW(1)
  ) dut_b (
    .clk(clk), .rst(rst), .key(key),
    .key_level(lvl_b), .key_press(prs_b), .key_release(rel_b),
    .key_long(lng_b), .key_repeat(rep_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scenarios: 0 short press + glitch, 1 long hold, 2 all keys, 3 release bounce, 4 reset mid-press.
  function automatic logic [3:0] pressed(input int s, input int c);
    case (s)
      0: return {2'b00, (c < 3), (c < 10)};
      1: return (c < 60) ? 4'h4 : 4'h0;
      2: return (c < 10) ? 4'hF : 4'h0;
      3: return (c < 10 || c == 12 || c == 13) ? 4'h1 : 4'h0;
      4: return 4'h1;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [3:0] exp_press(input int s, input int c);
    case (s)
      0, 3: return (c == 7) ? 4'h1 : 4'h0;
      1: return (c == 7) ? 4'h4 : 4'h0;
      2: return (c == 7) ? 4'hF : 4'h0;
      4: return (c == 7 || c == 32) ? 4'h1 : 4'h0;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [3:0] exp_release(input int s, input int c);
    case (s)
      0: return (c == 17) ? 4'h1 : 4'h0;
      1: return (c == 67) ? 4'h4 : 4'h0;
      2: return (c == 17) ? 4'hF : 4'h0;
      3: return (c == 21) ? 4'h1 : 4'h0;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [3:0] exp_long(input int s, input int c);
    return (s == 1 && c == 23) ? 4'h4 : 4'h0;
  endfunction

  function automatic logic [3:0] exp_repeat(input int s, input int c, input bit en);
    if (en && s == 1 && (c == 31 || c == 39 || c == 47 || c == 55)) return 4'h4;
    return 4'h0;
  endfunction

  function automatic logic [3:0] exp_level(input int s, input int c);
    case (s)
      0: return (c >= 7 && c <= 16) ? 4'h1 : 4'h0;
      1: return (c >= 7 && c <= 66) ? 4'h4 : 4'h0;
      2: return (c >= 7 && c <= 16) ? 4'hF : 4'h0;
      3: return (c >= 7 && c <= 20) ? 4'h1 : 4'h0;
      4: return ((c >= 7 && c <= 19) || c >= 32) ? 4'h1 : 4'h0;
      default: return 4'h0;
    endcase
  endfunction

  task automatic reset_idle();
    rst = 1'b1;
    key = 4'hF;
    #2;
    check("reset level", {28'd0, lvl_a}, 32'd0);
    check("reset pulses", {12'd0, prs_a, rel_a, lng_a, rep_a, lvl_b}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  // Cycle c starts at posedge c; inputs change at +1, outputs sampled at +2.
  task automatic run_scn(input int s, input int ncyc);
    @(posedge clk);
    #1;
    for (int c = 0; c <= ncyc; c++) begin
      key = ~pressed(s, c);
      if (s == 4) rst = (c >= 20 && c <= 24);
      #1;
      check($sformatf("s%0d c%0d a.press", s, c),   {28'd0, prs_a}, {28'd0, exp_press(s, c)});
      check($sformatf("s%0d c%0d a.release", s, c), {28'd0, rel_a}, {28'd0, exp_release(s, c)});
      check($sformatf("s%0d c%0d a.long", s, c),    {28'd0, lng_a}, {28'd0, exp_long(s, c)});
      check($sformatf("s%0d c%0d a.repeat", s, c),  {28'd0, rep_a}, {28'd0, exp_repeat(s, c, 1'b1)});
      check($sformatf("s%0d c%0d a.level", s, c),   {28'd0, lvl_a}, {28'd0, exp_level(s, c)});
      check($sformatf("s%0d c%0d b.press", s, c),   {28'd0, prs_b}, {28'd0, exp_press(s, c)});
      check($sformatf("s%0d c%0d b.release", s, c), {28'd0, rel_b}, {28'd0, exp_release(s, c)});
      check($sformatf("s%0d c%0d b.long", s, c),    {28'd0, lng_b}, {28'd0, exp_long(s, c)});
      check($sformatf("s%0d c%0d b.repeat", s, c),  {28'd0, rep_b}, {28'd0, exp_repeat(s, c, 1'b0)});
      check($sformatf("s%0d c%0d b.level", s, c),   {28'd0, lvl_b}, {28'd0, exp_level(s, c)});
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    key   = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    reset_idle();
    run_scn(0, 25);
    reset_idle();
    run_scn(1, 72);
    reset_idle();
    run_scn(2, 22);
    reset_idle();
    run_scn(3, 28);
    reset_idle();
    run_scn(4, 40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
